ds_rx_top: RTL and testbench
============================

Name: ds_rx_top

Overview:
Data/Strobe link receiver; the far end of the tx_top serializer.
- Synchronizes the D and S pins into rxClk and recovers one bit per D/S transition.
- Deframes characters: parity bit, lchar flag, then 2 data bits (control) or 8 data bits (data), LSB first.
- Checks odd parity and hands each character to the link layer through a one-entry valid/ready holding register.

Parameters:
SYNC_STAGES, 2, flops in the D/S input synchronizer; legal values 2..3.
DISC_CYCLES, 64, idle rxClk cycles with no D/S transition before a disconnect is declared (only with RX_DISCONNECT_EN).

Ports:
rxClk  input  1  receive clock; must be at least as fast as the far-end transmit bit rate.
rxReset_n  input  1  asynchronous active-low reset.
d  input  1  Data line, asynchronous to rxClk.
s  input  1  Strobe line, asynchronous to rxClk.
dat_o  output  8  received character; control characters on [1:0], with [7:2]=0.
lchar_o  output  1  1 = control character, 0 = data character.
valid_o  output  1  holding register full.
ready_i  input  1  consumer accepts dat_o/lchar_o when valid_o && ready_i.
parity_err_o  output  1  one-cycle pulse on a parity failure.
code_err_o  output  1  one-cycle pulse when D and S change in the same sample.
overrun_o  output  1  sticky; a character completed while the holding register was full. Cleared only by reset.
disc_o  output  1  sticky disconnect flag; exists only with RX_DISCONNECT_EN.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - All outputs 0.
  - Synchronizers 0; previous-sample register {dq,sq}=00.
  - Parity accumulator 0; FSM in PARITY.
- Bit recovery:
  - After SYNC_STAGES, compare {d,s} to {dq,sq}.
  - Exactly one changed: bit event with value = synchronized d.
  - Neither changed: no event.
  - Both changed: code_err_o pulses, the event is dropped, and the FSM returns to PARITY. The parity accumulator is not updated.
  - {dq,sq} updates every cycle.
- FSM (advances only on bit events):
  - PARITY: latch p. Go to FLAG.
  - FLAG: latch flag.
    - Compute chk = p ^ flag ^ acc, where acc is the XOR of the previous character's data bits.
    - If chk==0, parity_err_o pulses on this cycle; the character is still received.
    - Clear acc. Set bit count n=0 and len = flag ? 2 : 8. Go to DATA.
  - DATA: shift the bit into sh[n] (LSB first) and XOR it into acc. n increments.
    - On the bit where n reaches len: commit the character and go to PARITY.
- Commit:
  - Timing: on the cycle after the last data bit's event, dat_o = sh (upper bits zeroed for control characters), lchar_o = flag, and valid_o=1.
  - Latency from the final bit transition at the pins: SYNC_STAGES+2 rxClk cycles.
  - If the holding register is still full and not being accepted on the commit cycle: set overrun_o and overwrite with the new character.
  - If commit and accept happen on the same cycle: the new character is loaded and valid_o stays 1.
- Handshake: valid_o falls the cycle after the acceptance (valid_o && ready_i), unless a commit occurs on that same cycle.
- Reset asserted mid-character discards the partial character and the held character.

Optional Feature:
RX_DISCONNECT_EN
- With the macro defined:
  - A counter clears on every bit event and otherwise increments, saturating.
  - When it reaches DISC_CYCLES: disc_o=1 (sticky until reset), the FSM is forced to PARITY, acc is cleared, and bit events are ignored.
  - The counter is inactive until the first bit event after reset.
- Without the macro: no counter, no disc_o port, and a line held idle never resets the FSM.

Decomposition:
- Shared package ds_link_pkg:
  - FSM state enum {PARITY, FLAG, DATA}.
  - Constants CTRL_BITS=2 and DATA_BITS=8.
  - Parity-check helper function.
  - Also imported by tx_top.
- One sub-module, ds_bit_recover. It contains the synchronizer and {dq,sq} compare, and outputs bit_evt, bit_val and code_err.

Test Plan:
- Reset, then drive (d,s) one pair per 4 cycles: 01, 11, 01, 11 -> dat_o=8'h02, lchar_o=1, valid_o=1, parity_err_o never pulses.
- Continue with ready_i=1 and drive 10, 11, 01, 00 -> second character dat_o=8'h00, lchar_o=1, no parity error. valid_o deasserts after each acceptance.
- Data character 8'hA5: after the 8'h00 control character, send P=0 then flag=0 (p^flag^acc = 0^0^0 = 0 would flag an error, so use P=1), then data bits 1,0,1,0,0,1,0,1 -> dat_o=8'hA5, lchar_o=0, no error. Repeat with P inverted -> parity_err_o pulses exactly once and dat_o=8'hA5.
- With ready_i=0, send two control characters back to back -> overrun_o=1 and dat_o holds the second character. Raise ready_i -> valid_o falls on the next cycle.
- Drive both d and s to toggle in the same cycle mid-character -> code_err_o pulses once. The FSM resynchronizes and the next full character decodes correctly.
- With RX_DISCONNECT_EN and DISC_CYCLES=64: after one character, hold the lines -> disc_o rises at idle cycle 64 and stays 1 through further transitions until rxReset_n is asserted.

Source files
------------

// File: rtl/ds_link_pkg.sv
// rtl/ds_link_pkg.sv - shared Data/Strobe link types, character sizes and parity helper
package ds_link_pkg;

  typedef enum logic [1:0] {PARITY, FLAG, DATA} ds_state_e;

  localparam logic [3:0] CTRL_BITS = 4'd2;
  localparam logic [3:0] DATA_BITS = 4'd8;

  // Odd parity over the previous character's data bits, this parity bit and this flag.
  function automatic logic parity_ok(input logic p, input logic flag, input logic acc);
    return p ^ flag ^ acc;
  endfunction

endpackage

// File: rtl/ds_bit_recover.sv
// rtl/ds_bit_recover.sv - D/S synchronizer and transition detector producing one bit per event
module ds_bit_recover #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  input  logic s,
  output logic bit_evt,
  output logic bit_val,
  output logic code_err
);

  logic [SYNC_STAGES-1:0] d_sync;
  logic [SYNC_STAGES-1:0] s_sync;
  logic                   dq;
  logic                   sq;
  logic                   d_chg;
  logic                   s_chg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_sync <= '0;
      s_sync <= '0;
      dq     <= 1'b0;
      sq     <= 1'b0;
    end else begin
      d_sync <= {d_sync[SYNC_STAGES-2:0], d};
      s_sync <= {s_sync[SYNC_STAGES-2:0], s};
      dq     <= d_sync[SYNC_STAGES-1];
      sq     <= s_sync[SYNC_STAGES-1];
    end
  end

  assign d_chg    = d_sync[SYNC_STAGES-1] ^ dq;
  assign s_chg    = s_sync[SYNC_STAGES-1] ^ sq;
  assign bit_evt  = d_chg ^ s_chg;
  assign code_err = d_chg & s_chg;
  assign bit_val  = d_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ds_rx_top.sv
// rtl/ds_rx_top.sv - Data/Strobe receiver: deframer, parity check, holding register (RX_DISCONNECT_EN adds idle disconnect)
module ds_rx_top
  import ds_link_pkg::*;
#(
  parameter int SYNC_STAGES = 2
`ifdef RX_DISCONNECT_EN
  ,
  parameter int DISC_CYCLES = 64
`endif
) (
  input  logic       rxClk,
  input  logic       rxReset_n,
  input  logic       d,
  input  logic       s,
  output logic [7:0] dat_o,
  output logic       lchar_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       parity_err_o,
  output logic       code_err_o,
  output logic       overrun_o
`ifdef RX_DISCONNECT_EN
  ,
  output logic       disc_o
`endif
);

  logic       bit_evt;
  logic       bit_val;
  logic       code_err;
  logic       ev;
  logic       disc_hit;
  ds_state_e  state_q;
  ds_state_e  state_d;
  logic       p_q;
  logic       flag_q;
  logic       acc_q;
  logic [7:0] sh_q;
  logic [3:0] n_q;
  logic       commit_q;
  logic [3:0] len;
  logic       last_bit;

  ds_bit_recover #(.SYNC_STAGES(SYNC_STAGES)) u_bit_recover (
    .clk      (rxClk),
    .rst_n    (rxReset_n),
    .d        (d),
    .s        (s),
    .bit_evt  (bit_evt),
    .bit_val  (bit_val),
    .code_err (code_err)
  );

`ifdef RX_DISCONNECT_EN
  localparam int DW = $clog2(DISC_CYCLES + 1);
  logic [DW-1:0] idle_q;
  logic          armed_q;

  // The counter only arms after the first bit so a quiet line out of reset is not a disconnect.
  assign disc_hit = armed_q && !disc_o && !bit_evt && (idle_q == DW'(DISC_CYCLES - 1));
  assign ev       = bit_evt && !disc_o;

  always_ff @(posedge rxClk or negedge rxReset_n) begin
    if (!rxReset_n) begin
      idle_q  <= '0;
      armed_q <= 1'b0;
      disc_o  <= 1'b0;
    end else begin
      if (bit_evt) begin
        idle_q  <= '0;
        armed_q <= 1'b1;
      end else if (armed_q && idle_q != DW'(DISC_CYCLES)) begin
        idle_q <= idle_q + 1'b1;
      end
      if (disc_hit) disc_o <= 1'b1;
    end
  end
`else
  assign disc_hit = 1'b0;
  assign ev       = bit_evt;
`endif

  assign len      = flag_q ? CTRL_BITS : DATA_BITS;
  assign last_bit = (n_q == len - 4'd1);

  always_ff @(posedge rxClk or negedge rxReset_n) begin
    if (!rxReset_n) state_q <= PARITY;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (code_err || disc_hit) begin
      state_d = PARITY;
    end else if (ev) begin
      case (state_q)
        PARITY:  state_d = FLAG;
        FLAG:    state_d = DATA;
        DATA:    if (last_bit) state_d = PARITY;
        default: state_d = PARITY;
      endcase
    end
  end

  always_ff @(posedge rxClk or negedge rxReset_n) begin
    if (!rxReset_n) begin
      p_q          <= 1'b0;
      flag_q       <= 1'b0;
      acc_q        <= 1'b0;
      sh_q         <= '0;
      n_q          <= '0;
      commit_q     <= 1'b0;
      parity_err_o <= 1'b0;
      code_err_o   <= 1'b0;
    end else begin
      parity_err_o <= 1'b0;
      code_err_o   <= code_err;
      commit_q     <= 1'b0;
      if (disc_hit) begin
        acc_q <= 1'b0;
      end else if (ev) begin
        case (state_q)
          PARITY: p_q <= bit_val;
          FLAG: begin
            flag_q       <= bit_val;
            parity_err_o <= !parity_ok(p_q, bit_val, acc_q);
            acc_q        <= 1'b0;
            n_q          <= '0;
            sh_q         <= '0;
          end
          DATA: begin
            sh_q[n_q[2:0]] <= bit_val;
            acc_q          <= acc_q ^ bit_val;
            n_q            <= n_q + 4'd1;
            commit_q       <= last_bit;
          end
          default: ;
        endcase
      end
    end
  end

  // Commit is one cycle behind the last data bit so sh_q already holds it.
  always_ff @(posedge rxClk or negedge rxReset_n) begin
    if (!rxReset_n) begin
      dat_o     <= '0;
      lchar_o   <= 1'b0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else if (commit_q) begin
      dat_o   <= flag_q ? {6'b0, sh_q[1:0]} : sh_q;
      lchar_o <= flag_q;
      valid_o <= 1'b1;
      if (valid_o && !ready_i) overrun_o <= 1'b1;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ds_rx_top.sv
// tb/tb_ds_rx_top.sv - directed self-checking bench for ds_rx_top (covers RX_DISCONNECT_EN when defined)
module tb_ds_rx_top;

  logic       clk;
  logic       rst_n;
  logic       d_pin;
  logic       s_pin;
  logic [7:0] dat_o;
  logic       lchar_o;
  logic       valid_o;
  logic       ready_i;
  logic       parity_err_o;
  logic       code_err_o;
  logic       overrun_o;
`ifdef RX_DISCONNECT_EN
  logic       disc_o;
`endif

  int total = 0;
  int bad   = 0;
  int perr_cnt = 0;
  int cerr_cnt = 0;
  int base;
  int cycles;
  logic acc_m;
  logic [8:0] rxq[$];
  logic [8:0] got;

  ds_rx_top dut (
    .rxClk        (clk),
    .rxReset_n    (rst_n),
    .d            (d_pin),
    .s            (s_pin),
    .dat_o        (dat_o),
    .lchar_o      (lchar_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .parity_err_o (parity_err_o),
    .code_err_o   (code_err_o),
    .overrun_o    (overrun_o)
`ifdef RX_DISCONNECT_EN
    ,
    .disc_o       (disc_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (parity_err_o) perr_cnt++;
    if (code_err_o) cerr_cnt++;
    if (valid_o && ready_i) rxq.push_back({lchar_o, dat_o});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_pair(input logic nd, input logic ns);
    d_pin = nd;
    s_pin = ns;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    if (b != d_pin) drive_pair(~d_pin, s_pin);
    else            drive_pair(d_pin, ~s_pin);
  endtask

  task automatic send_char(input logic lc, input logic [7:0] data, input logic bad_par, input int idle);
    int nb;
    logic p;
    nb = lc ? 2 : 8;
    p  = 1'b1 ^ lc ^ acc_m ^ bad_par;
    send_bit(p);
    send_bit(lc);
    repeat (idle) @(negedge clk);
    acc_m = 1'b0;
    for (int i = 0; i < nb; i++) begin
      send_bit(data[i]);
      acc_m = acc_m ^ data[i];
    end
  endtask

  task automatic expect_char(input string tag, input logic [8:0] exp);
    check({tag, "_n"}, rxq.size(), 1);
    if (rxq.size() > 0) begin
      got = rxq.pop_front();
      check(tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    d_pin   = 1'b0;
    s_pin   = 1'b0;
    acc_m   = 1'b0;
    repeat (3) @(negedge clk);
    rxq.delete();
  endtask

  initial begin
    ready_i = 1'b0;
    do_reset();
    check("rst_valid", valid_o, 0);
    check("rst_dat", dat_o, 0);
    check("rst_lchar", lchar_o, 0);
    check("rst_ovr", overrun_o, 0);
    check("rst_perr", parity_err_o, 0);
`ifdef RX_DISCONNECT_EN
    check("rst_disc", disc_o, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // control char 2'b10 from hand-drawn pairs
    drive_pair(1'b0, 1'b1);
    drive_pair(1'b1, 1'b1);
    drive_pair(1'b0, 1'b1);
    d_pin = 1'b1;
    s_pin = 1'b1;
    repeat (3) @(negedge clk);
    check("lat_early", valid_o, 0);
    @(negedge clk);
    check("c1_valid", valid_o, 1);
    check("c1_dat", dat_o, 8'h02);
    check("c1_lchar", lchar_o, 1);
    check("c1_perr", perr_cnt, 0);
    acc_m = 1'b1;

    ready_i = 1'b1;
    @(negedge clk);
    check("c1_vfall", valid_o, 0);
    expect_char("c1_acc", 9'h102);

    drive_pair(1'b1, 1'b0);
    drive_pair(1'b1, 1'b1);
    drive_pair(1'b0, 1'b1);
    d_pin = 1'b0;
    s_pin = 1'b0;
    repeat (4) @(negedge clk);
    check("c2_valid", valid_o, 1);
    check("c2_dat", dat_o, 8'h00);
    @(negedge clk);
    check("c2_vfall", valid_o, 0);
    expect_char("c2_acc", 9'h100);
    check("c2_perr", perr_cnt, 0);
    acc_m = 1'b0;

    base = perr_cnt;
    send_char(1'b0, 8'hA5, 1'b0, 0);
    repeat (2) @(negedge clk);
    expect_char("a5_good", 9'h0A5);
    check("a5_good_perr", perr_cnt - base, 0);
    base = perr_cnt;
    send_char(1'b0, 8'hA5, 1'b1, 0);
    repeat (2) @(negedge clk);
    expect_char("a5_bad", 9'h0A5);
    check("a5_bad_perr", perr_cnt - base, 1);

    ready_i = 1'b0;
    send_char(1'b1, 8'h01, 1'b0, 0);
    check("ovr_before", overrun_o, 0);
    send_char(1'b1, 8'h02, 1'b0, 0);
    check("ovr_set", overrun_o, 1);
    check("ovr_dat", dat_o, 8'h02);
    check("ovr_valid", valid_o, 1);
    ready_i = 1'b1;
    @(negedge clk);
    check("ovr_vfall", valid_o, 0);
    expect_char("ovr_acc", 9'h102);
    check("ovr_sticky", overrun_o, 1);

    base = cerr_cnt;
    send_bit(1'b0);
    drive_pair(~d_pin, ~s_pin);
    check("cerr_pulse", cerr_cnt - base, 1);
    base = perr_cnt;
    send_char(1'b1, 8'h03, 1'b0, 0);
    repeat (2) @(negedge clk);
    expect_char("cerr_resync", 9'h103);
    check("cerr_perr", perr_cnt - base, 0);

`ifdef RX_DISCONNECT_EN
    send_char(1'b1, 8'h01, 1'b0, 0);
    cycles = 4;
    while (!disc_o && cycles < 300) begin
      @(negedge clk);
      cycles++;
    end
    check("disc_window", (cycles >= 64 && cycles <= 70), 1);
    rxq.delete();
    acc_m = 1'b0;
    send_char(1'b1, 8'h02, 1'b0, 0);
    repeat (2) @(negedge clk);
    check("disc_sticky", disc_o, 1);
    check("disc_ignored", rxq.size(), 0);
    do_reset();
    check("disc_rst", disc_o, 0);
    rst_n = 1'b1;
    repeat (120) @(negedge clk);
    check("disc_unarmed", disc_o, 0);
`else
    base = perr_cnt;
    send_char(1'b1, 8'h01, 1'b0, 200);
    repeat (2) @(negedge clk);
    expect_char("idle_hold", 9'h101);
    check("idle_perr", perr_cnt - base, 0);
`endif

    ready_i = 1'b0;
    send_char(1'b0, 8'h5A, 1'b0, 0);
    send_bit(1'b1);
    send_bit(1'b0);
    do_reset();
    check("mid_rst_valid", valid_o, 0);
    check("mid_rst_ovr", overrun_o, 0);
    check("mid_rst_dat", dat_o, 0);
    rst_n   = 1'b1;
    ready_i = 1'b1;
    @(negedge clk);
    base = perr_cnt;
    send_char(1'b0, 8'h3C, 1'b0, 0);
    repeat (2) @(negedge clk);
    expect_char("post_rst", 9'h03C);
    check("post_rst_perr", perr_cnt - base, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
